// File: rtl/plab4_net_sched_pkg.sv
// Shared state encodings and domain constants for the two-domain
// time-division network scheduler.
package plab4_net_sched_pkg;

    typedef enum logic [1:0] {
        ST_D1 = 2'd0,
        ST_G1 = 2'd1,
        ST_D2 = 2'd2,
        ST_G2 = 2'd3
    } state_t;

    localparam logic DOM_D1 = 1'b0;
    localparam logic DOM_D2 = 1'b1;

endpackage

// File: rtl/plab4_net_slot_timer.sv
// Fixed-schedule slot timer: D1 slot, guard, D2 slot, guard, repeating.
// Advances on cycle count alone, never on traffic.
module plab4_net_slot_timer
    import plab4_net_sched_pkg::*;
#(
    parameter int unsigned p_slot_len  = 8,
    parameter int unsigned p_guard_len = 1
) (
    input  logic   clk,
    input  logic   reset,
    output state_t state,
    output logic   slot_start
);

    localparam int unsigned c_max = (p_slot_len > p_guard_len) ? p_slot_len : p_guard_len;
    localparam int unsigned c_cw  = (c_max > 1) ? $clog2(c_max) : 1;

    localparam logic [c_cw-1:0] c_slot_last  = c_cw'(p_slot_len - 1);
    localparam logic [c_cw-1:0] c_guard_last = c_cw'(p_guard_len - 1);

    state_t          state_next;
    logic [c_cw-1:0] cnt;
    logic [c_cw-1:0] cnt_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_D1;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt + c_cw'(1);
        unique case (state)
            ST_D1: if (cnt == c_slot_last) begin
                state_next = ST_G1;
                cnt_next   = '0;
            end
            ST_G1: if (cnt == c_guard_last) begin
                state_next = ST_D2;
                cnt_next   = '0;
            end
            ST_D2: if (cnt == c_slot_last) begin
                state_next = ST_G2;
                cnt_next   = '0;
            end
            ST_G2: if (cnt == c_guard_last) begin
                state_next = ST_D1;
                cnt_next   = '0;
            end
            default: begin
                state_next = ST_D1;
                cnt_next   = '0;
            end
        endcase
    end

    // Suppressed during reset so a mid-slot reset never leaks a pulse.
    assign slot_start = !reset && (cnt == '0) && ((state == ST_D1) || (state == ST_D2));

endmodule

// File: rtl/plab4_net_domain_sched.sv
// Two-domain time-division scheduler: merges D1/D2 requesters onto one
// channel with a fixed, traffic-independent slot schedule.
module plab4_net_domain_sched
    import plab4_net_sched_pkg::*;
#(
    parameter int unsigned p_msg_cnbits = 32,
    parameter int unsigned p_msg_dnbits = 32,
    parameter int unsigned p_slot_len   = 8,
    parameter int unsigned p_guard_len  = 1
) (
    input  logic                    clk,
    input  logic                    reset,

    input  logic                    in_val_d1,
    output logic                    in_rdy_d1,
    input  logic [p_msg_cnbits-1:0] in_msg_control_d1,
    input  logic [p_msg_dnbits-1:0] in_msg_data_d1,

    input  logic                    in_val_d2,
    output logic                    in_rdy_d2,
    input  logic [p_msg_cnbits-1:0] in_msg_control_d2,
    input  logic [p_msg_dnbits-1:0] in_msg_data_d2,

    output logic                    out_val,
    input  logic                    out_rdy,
    output logic [p_msg_cnbits-1:0] out_msg_control,
    output logic [p_msg_dnbits-1:0] out_msg_data,

    output logic                    domain,
    output logic                    slot_start
);

    state_t state;

    plab4_net_slot_timer #(
        .p_slot_len  (p_slot_len),
        .p_guard_len (p_guard_len)
    ) slot_timer (
        .clk        (clk),
        .reset      (reset),
        .state      (state),
        .slot_start (slot_start)
    );

    // Reset gates every output combinationally: the state register may still
    // hold a mid-slot value during the first reset cycle.
    always_comb begin
        out_val         = 1'b0;
        in_rdy_d1       = 1'b0;
        in_rdy_d2       = 1'b0;
        out_msg_control = '0;
        out_msg_data    = '0;
        domain          = DOM_D1;
        if (!reset) begin
            unique case (state)
                ST_D1: begin
                    out_val         = in_val_d1;
                    in_rdy_d1       = out_rdy;
                    out_msg_control = in_msg_control_d1;
                    out_msg_data    = in_msg_data_d1;
                    domain          = DOM_D1;
                end
                ST_G1: domain = DOM_D1;
                ST_D2: begin
                    out_val         = in_val_d2;
                    in_rdy_d2       = out_rdy;
                    out_msg_control = in_msg_control_d2;
                    out_msg_data    = in_msg_data_d2;
                    domain          = DOM_D2;
                end
                ST_G2: domain = DOM_D2;
                default: domain = DOM_D1;
            endcase
        end
    end

endmodule

// File: tb/tb_plab4_net_domain_sched.sv
// Directed bench for plab4_net_domain_sched: schedule, streaming, isolation,
// backpressure, mid-slot reset and an alternate slot/guard configuration.
module tb_plab4_net_domain_sched;

    logic        clk;
    logic        reset;

    logic        val1, rdy1, val2, rdy2, oval, ordy, dom, sst;
    logic [31:0] ctl1, dat1, ctl2, dat2, octl, odat;

    logic        b_val1, b_rdy1, b_val2, b_rdy2, b_oval, b_ordy, b_dom, b_sst;
    logic [31:0] b_ctl1, b_dat1, b_ctl2, b_dat2, b_octl, b_odat;

    int checks;
    int errors;

    plab4_net_domain_sched #(
        .p_msg_cnbits (32),
        .p_msg_dnbits (32),
        .p_slot_len   (4),
        .p_guard_len  (1)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .in_val_d1         (val1),
        .in_rdy_d1         (rdy1),
        .in_msg_control_d1 (ctl1),
        .in_msg_data_d1    (dat1),
        .in_val_d2         (val2),
        .in_rdy_d2         (rdy2),
        .in_msg_control_d2 (ctl2),
        .in_msg_data_d2    (dat2),
        .out_val           (oval),
        .out_rdy           (ordy),
        .out_msg_control   (octl),
        .out_msg_data      (odat),
        .domain            (dom),
        .slot_start        (sst)
    );

    plab4_net_domain_sched #(
        .p_msg_cnbits (32),
        .p_msg_dnbits (32),
        .p_slot_len   (2),
        .p_guard_len  (3)
    ) dut_b (
        .clk               (clk),
        .reset             (reset),
        .in_val_d1         (b_val1),
        .in_rdy_d1         (b_rdy1),
        .in_msg_control_d1 (b_ctl1),
        .in_msg_data_d1    (b_dat1),
        .in_val_d2         (b_val2),
        .in_rdy_d2         (b_rdy2),
        .in_msg_control_d2 (b_ctl2),
        .in_msg_data_d2    (b_dat2),
        .out_val           (b_oval),
        .out_rdy           (b_ordy),
        .out_msg_control   (b_octl),
        .out_msg_data      (b_odat),
        .domain            (b_dom),
        .slot_start        (b_sst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic idle_inputs();
        val1 = 1'b0; val2 = 1'b0; ordy = 1'b1;
        ctl1 = '0; dat1 = '0; ctl2 = '0; dat2 = '0;
        b_val1 = 1'b0; b_val2 = 1'b0; b_ordy = 1'b1;
        b_ctl1 = '0; b_dat1 = '0; b_ctl2 = '0; b_dat2 = '0;
    endtask

    // Leaves the bench at the negedge that begins cycle 0 (reset just dropped).
    task automatic start();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        val1 = 1'b1; val2 = 1'b1; dat1 = 32'h11; dat2 = 32'h22; ctl1 = 32'h5; ctl2 = 32'h6;
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            checks++;
            if ({oval, rdy1, rdy2, dom, sst} !== 5'b0) begin
                errors++;
                $display("FAIL reset_ctrl cycle %0d: got val/rdy1/rdy2/dom/sst=%b required 00000", c, {oval, rdy1, rdy2, dom, sst});
            end
            checks++;
            if (odat !== 32'h0 || octl !== 32'h0) begin
                errors++;
                $display("FAIL reset_msg cycle %0d: got ctl=%h data=%h required 0/0", c, octl, odat);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (sst !== 1'b1 || dom !== 1'b0 || oval !== 1'b1 || odat !== 32'h11) begin
            errors++;
            $display("FAIL reset_release: got sst=%b dom=%b val=%b data=%h required 1 0 1 00000011", sst, dom, oval, odat);
        end
    endtask

    task automatic test_schedule();
        logic exp_dom, exp_sst;
        idle_inputs();
        dat2 = 32'h77;
        start();
        for (int c = 0; c < 21; c++) begin
            #1;
            exp_dom = (c % 10) >= 5;
            exp_sst = (c % 10 == 0) || (c % 10 == 5);
            checks++;
            if (dom !== exp_dom || sst !== exp_sst || oval !== 1'b0) begin
                errors++;
                $display("FAIL schedule cycle %0d: got dom=%b sst=%b val=%b required %b %b 0", c, dom, sst, oval, exp_dom, exp_sst);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_d1_stream();
        int   idx;
        logic exp_val;
        idle_inputs();
        idx = 0;
        start();
        for (int c = 0; c < 11; c++) begin
            val1 = 1'b1;
            dat1 = 32'hA0 + idx;
            ctl1 = 32'h100 + idx;
            #1;
            exp_val = (c % 10) < 4;
            checks++;
            if (oval !== exp_val || rdy1 !== exp_val) begin
                errors++;
                $display("FAIL d1_stream_hs cycle %0d: got val=%b rdy1=%b required %b %b", c, oval, rdy1, exp_val, exp_val);
            end
            if (exp_val) begin
                checks++;
                if (odat !== 32'hA0 + idx || octl !== 32'h100 + idx) begin
                    errors++;
                    $display("FAIL d1_stream_msg cycle %0d: got ctl=%h data=%h required %h %h", c, octl, odat, 32'h100 + idx, 32'hA0 + idx);
                end
            end
            if (oval && ordy) idx++;
            @(negedge clk);
        end
        checks++;
        if (idx !== 5) begin
            errors++;
            $display("FAIL d1_stream_count: got %0d transfers required 5", idx);
        end
    endtask

    task automatic test_isolation();
        logic [19:0] mask [2];
        logic [19:0] exp_mask;
        exp_mask = 20'b0000_0111_1000_0001_1110_0000;
        for (int run = 0; run < 2; run++) begin
            idle_inputs();
            mask[run] = '0;
            start();
            for (int c = 0; c < 20; c++) begin
                val1 = (run == 1);
                dat1 = 32'hD1D1_0000 + c;
                val2 = 1'b1;
                dat2 = 32'hB0 + c;
                #1;
                if (oval && ordy && dom) mask[run][c] = 1'b1;
                if ((c % 10 == 4) || (c % 10 == 9)) begin
                    checks++;
                    if (odat !== 32'h0 || oval !== 1'b0) begin
                        errors++;
                        $display("FAIL iso_guard run %0d cycle %0d: got val=%b data=%h required 0 0", run, c, oval, odat);
                    end
                end
                if ((c % 10) >= 5 && (c % 10) <= 8) begin
                    checks++;
                    if (odat !== 32'hB0 + c) begin
                        errors++;
                        $display("FAIL iso_d2_data run %0d cycle %0d: got %h required %h", run, c, odat, 32'hB0 + c);
                    end
                end
                @(negedge clk);
            end
            checks++;
            if (mask[run] !== exp_mask) begin
                errors++;
                $display("FAIL iso_d2_cycles run %0d: got %b required %b", run, mask[run], exp_mask);
            end
        end
    endtask

    task automatic test_backpressure();
        int xfers;
        int xfer_cycle;
        idle_inputs();
        xfers = 0;
        xfer_cycle = -1;
        start();
        for (int c = 0; c < 10; c++) begin
            val2 = 1'b1;
            dat2 = 32'hC0 + c;
            ordy = (c < 5) || (c == 8);
            #1;
            if (c >= 5) begin
                checks++;
                if (rdy1 !== 1'b0 || rdy2 !== ((c <= 8) ? ordy : 1'b0)) begin
                    errors++;
                    $display("FAIL bp_rdy cycle %0d: got rdy1=%b rdy2=%b required 0 %b", c, rdy1, rdy2, (c <= 8) ? ordy : 1'b0);
                end
                if (oval && ordy) begin
                    xfers++;
                    xfer_cycle = c;
                end
            end
            @(negedge clk);
        end
        checks++;
        if (xfers !== 1 || xfer_cycle !== 8) begin
            errors++;
            $display("FAIL bp_xfer: got %0d transfers at cycle %0d required 1 at 8", xfers, xfer_cycle);
        end
    endtask

    task automatic test_reset_mid();
        logic exp_val, exp_dom, exp_sst;
        idle_inputs();
        val1 = 1'b1; val2 = 1'b1; dat1 = 32'hE1; dat2 = 32'hE2;
        start();
        repeat (7) @(negedge clk);
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            #1;
            checks++;
            if ({oval, rdy1, rdy2, dom, sst} !== 5'b0 || odat !== 32'h0) begin
                errors++;
                $display("FAIL midreset_out %0d: got val/rdy1/rdy2/dom/sst=%b data=%h required 00000 0", c, {oval, rdy1, rdy2, dom, sst}, odat);
            end
            @(negedge clk);
        end
        reset = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #1;
            exp_val = (c != 4);
            exp_dom = (c == 5);
            exp_sst = (c == 0) || (c == 5);
            checks++;
            if (oval !== exp_val || dom !== exp_dom || sst !== exp_sst) begin
                errors++;
                $display("FAIL midreset_after cycle %0d: got val=%b dom=%b sst=%b required %b %b %b", c, oval, dom, sst, exp_val, exp_dom, exp_sst);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_params();
        logic exp_v1, exp_v2, exp_dom, exp_sst;
        int   p;
        idle_inputs();
        b_val1 = 1'b1; b_val2 = 1'b1; b_dat1 = 32'h51; b_dat2 = 32'h52;
        start();
        for (int c = 0; c < 20; c++) begin
            #1;
            p = c % 10;
            exp_v1  = (p < 2);
            exp_v2  = (p == 5) || (p == 6);
            exp_dom = (p >= 5);
            exp_sst = (p == 0) || (p == 5);
            checks++;
            if (b_oval !== (exp_v1 | exp_v2) || b_rdy1 !== exp_v1 || b_rdy2 !== exp_v2 ||
                b_dom !== exp_dom || b_sst !== exp_sst) begin
                errors++;
                $display("FAIL params cycle %0d: got val=%b rdy1=%b rdy2=%b dom=%b sst=%b required %b %b %b %b %b",
                         c, b_oval, b_rdy1, b_rdy2, b_dom, b_sst, exp_v1 | exp_v2, exp_v1, exp_v2, exp_dom, exp_sst);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        @(negedge clk);
        test_reset();
        test_schedule();
        test_d1_stream();
        test_isolation();
        test_backpressure();
        test_reset_mid();
        test_params();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
